// File: rtl/div_job_sequencer.sv
// div_job_sequencer: buffers operand pairs, issues one divide job at a time,
// and returns each quotient/remainder with a status code on a valid/ready port.
module div_job_sequencer #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic [WIDTH-1:0] div_x,
  output logic [WIDTH-1:0] div_y,
  output logic             go,
  output logic             error,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic [1:0]       out_status,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] mem_x_q [DEPTH];
  logic [WIDTH-1:0] mem_x_d [DEPTH];
  logic [WIDTH-1:0] mem_y_q [DEPTH];
  logic [WIDTH-1:0] mem_y_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [WIDTH-1:0] div_x_q, div_x_d, div_y_q, div_y_d;
  logic [WIDTH-1:0] out_q_q, out_q_d, out_r_q, out_r_d;
  logic [1:0] out_status_q, out_status_d;
  logic go_q, go_d, error_q, error_d, out_valid_q, out_valid_d;
  logic push, pop;
  assign in_ready   = cnt_q != CW'(DEPTH);
  assign push       = in_valid && in_ready;
  assign busy       = state_q != IDLE || cnt_q != '0;
  assign div_x      = div_x_q;
  assign div_y      = div_y_q;
  assign go         = go_q;
  assign error      = error_q;
  assign out_valid  = out_valid_q;
  assign out_q      = out_q_q;
  assign out_r      = out_r_q;
  assign out_status = out_status_q;
  always_comb begin
    mem_x_d = mem_x_q;
    mem_y_d = mem_y_q;
    if (push) begin
      mem_x_d[wr_ptr_q] = in_x;
      mem_y_d[wr_ptr_q] = in_y;
    end
    state_d      = state_q;
    div_x_d      = div_x_q;
    div_y_d      = div_y_q;
    timer_d      = timer_q;
    out_q_d      = out_q_q;
    out_r_d      = out_r_q;
    out_status_d = out_status_q;
    pop          = 1'b0;
    case (state_q)
      IDLE: if (cnt_q != '0) begin
        pop     = 1'b1;
        div_x_d = mem_x_q[rd_ptr_q];
        div_y_d = mem_y_q[rd_ptr_q];
        state_d = ISSUE;
      end
      ISSUE: if (div_y_q == '0) begin
        out_q_d      = '1;
        out_r_d      = div_x_q;
        out_status_d = 2'b01;
        state_d      = RESP;
      end else begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: if (div_done) begin
        out_q_d      = div_q;
        out_r_d      = div_r;
        out_status_d = 2'b00;
        state_d      = RESP;
      end else if (timer_q == TW'(TIMEOUT - 1)) begin
        out_q_d      = '0;
        out_r_d      = '0;
        out_status_d = 2'b10;
        state_d      = RESP;
      end else begin
        timer_d = &timer_q ? timer_q : timer_q + 1'b1;
      end
      RESP: state_d = out_ready ? IDLE : RESP;
    endcase
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d       = cnt_q + CW'(push) - CW'(pop);
    go_d        = state_d == ISSUE;
    error_d     = go_d && div_y_d == '0;
    out_valid_d = state_d == RESP;
  end
  always_ff @(posedge clk) begin
    mem_x_q <= mem_x_d;
    mem_y_q <= mem_y_d;
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      timer_q      <= '0;
      div_x_q      <= '0;
      div_y_q      <= '0;
      out_q_q      <= '0;
      out_r_q      <= '0;
      out_status_q <= 2'b00;
      go_q         <= 1'b0;
      error_q      <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      div_x_q      <= div_x_d;
      div_y_q      <= div_y_d;
      out_q_q      <= out_q_d;
      out_r_q      <= out_r_d;
      out_status_q <= out_status_d;
      go_q         <= go_d;
      error_q      <= error_d;
      out_valid_q  <= out_valid_d;
    end
  end
endmodule
